instruction_decode_stage: RTL and testbench
===========================================

Name: instruction_decode_stage

Overview:
MIPS pipeline ID stage, sitting between the IF/ID and ID/EX pipeline registers. It contains the 32x32 register file, the main controller and the immediate extender. It decodes the current instruction into register operands, immediate, register fields, jump target and control signals for EX/MEM/WB. All outputs are combinational from Instruction, PCAddResult and register-file state; only the register file is clocked.

Parameters:
none

Ports:
Clk  in  1  clock; register file writes on rising edge
Reset  in  1  synchronous active-high reset; clears all 32 registers
Instruction  in  32  instruction from IF/ID
PCAddResult  in  32  PC+4 from IF/ID
RegWrite  in  1  write enable from WB stage
WriteRegister  in  5  WB destination register
WriteData  in  32  WB data
ReadData1  out  32  GPR[rs]
ReadData2  out  32  GPR[rt]
SignExtension  out  32  extended imm16
PCAddResult_out  out  32  PCAddResult passed through
instruction_indx  out  32  jump target {PCAddResult[31:28], Instruction[25:0], 2'b00}
Rt  out  5  Instruction[20:16]
Rd  out  5  Instruction[15:11]; forced to 31 for jal
ALUSrc  out  1  1 = immediate as ALU operand B
ALUOp  out  4  ALU operation
Branch  out  1  conditional branch
BranchLogicOp  out  3  branch condition
RegDst  out  1  1 = destination Rd, 0 = Rt
RegWrite1  out  1  instruction writes a GPR
MemWrite  out  1  store
MemRead  out  1  load
MemToReg  out  1  write-back from memory
BitSel  out  2  access width: 00 word, 01 half, 10 byte
sel_D  out  2  next-PC source: 00 sequential/branch, 01 jump target (j/jal), 10 ReadData1 (jr)

Behaviour:
- Register file:
  - Reset (sync, rising edge) clears all registers to 0.
  - Write on rising Clk when RegWrite=1 and WriteRegister!=0.
  - $0 always reads 0.
  - Reads are combinational with write-through bypass: if RegWrite=1, WriteRegister!=0 and it equals rs/rt, the read returns WriteData.
- Immediate: zero-extended for andi/ori/xori; sign-extended for all others. Shift amount for sll/srl is taken by EX from SignExtension[10:6].
- ALUOp codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOR, 0101 XOR, 0110 SLL, 0111 SRL, 1000 SLT, 1001 MUL, 1111 LINK (EX passes PCAddResult_out).
- BranchLogicOp codes: 000 BEQ, 001 BNE, 010 BGEZ, 011 BGTZ, 100 BLEZ, 101 BLTZ. Value is 000 when Branch=0. Branch instructions use ALUOp=SUB.
- Decode (controls not listed are 0):
  - R-type add/sub/and/or/nor/xor/slt/sll/srl, and mul (op 0x1C, funct 0x02): RegDst=1, RegWrite1=1, ALUOp per function.
  - addi/slti/andi/ori/xori: ALUSrc=1, RegWrite1=1, ALUOp ADD/SLT/AND/OR/XOR.
  - lw/lh/lb: ALUSrc=1, MemRead=1, MemToReg=1, RegWrite1=1, ALUOp=ADD, BitSel 00/01/10.
  - sw/sh/sb: ALUSrc=1, MemWrite=1, ALUOp=ADD, BitSel 00/01/10.
  - beq/bne/bgtz/blez: Branch=1. REGIMM (op 1) rt=1 gives BGEZ; rt=0 gives BLTZ.
  - j: sel_D=01.
  - jal: sel_D=01, RegWrite1=1, RegDst=1, Rd=31, ALUOp=LINK.
  - jr (funct 0x08): sel_D=10, RegWrite1=0.
  - Instruction==0 (NOP) and any unknown opcode/funct: all controls 0.
- Latency: combinational, zero cycles. A register written at edge N is visible immediately through the bypass, and from the array after edge N.

Test Plan:
- Reset=1 for one edge, then ReadData1/ReadData2=0 for any rs/rt. Write 5 to $8 and 3 to $9, then decode 0x01095020 -> ReadData1=5, ReadData2=3, Rd=10, RegDst=1, RegWrite1=1, ALUOp=0000.
- 0x20080005 -> SignExtension=5, Rt=8, ALUSrc=1, RegDst=0, RegWrite1=1. 0x2008FFFF -> SignExtension=0xFFFFFFFF. 0x3008FFFF -> SignExtension=0x0000FFFF, ALUOp=0010.
- 0xADA80000 -> MemWrite=1, RegWrite1=0, BitSel=00. 0x85B20006 -> MemRead=1, MemToReg=1, BitSel=01, SignExtension=6. 0xA1A90004 -> MemWrite=1, BitSel=10.
- 0x1108000B -> Branch=1, BranchLogicOp=000, SignExtension=0xB. 0x0501000B -> BranchLogicOp=010. 0x0520000B -> BranchLogicOp=101.
- PCAddResult=1 with 0x0C0000EA -> instruction_indx=0x000003A8, sel_D=01, Rd=31, RegWrite1=1, ALUOp=1111. 0x03E00008 -> sel_D=10, RegWrite1=0. 0x00000000 -> all controls 0.
- RegWrite=1, WriteRegister=0, WriteData=2, then read $0 -> 0. Same-cycle write to $9 while decoding rs=$9 -> ReadData1 equals WriteData.

Source files
------------

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: 32x32 register file with write-through bypass,
// main controller and immediate extender. Only the GPR array is clocked.
module instruction_decode_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic [31:0] PCAddResult,
    input  logic        RegWrite,
    input  logic [4:0]  WriteRegister,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] SignExtension,
    output logic [31:0] PCAddResult_out,
    output logic [31:0] instruction_indx,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic        ALUSrc,
    output logic [3:0]  ALUOp,
    output logic        Branch,
    output logic [2:0]  BranchLogicOp,
    output logic        RegDst,
    output logic        RegWrite1,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic [1:0]  BitSel,
    output logic [1:0]  sel_D
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_MUL  = 4'b1001;
    localparam logic [3:0] ALU_LINK = 4'b1111;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BGEZ = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLEZ = 3'b100;
    localparam logic [2:0] BR_BLTZ = 3'b101;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_MUL    = 6'h1C;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    logic [31:0] r_gpr [32];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [15:0] w_imm;
    logic        w_wr_en;
    logic        w_zext;
    logic        w_jal;

    assign w_op    = Instruction[31:26];
    assign w_rs    = Instruction[25:21];
    assign w_rt    = Instruction[20:16];
    assign w_funct = Instruction[5:0];
    assign w_imm   = Instruction[15:0];
    assign w_wr_en = RegWrite && (WriteRegister != 5'd0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_gpr[WriteRegister] <= WriteData;
        end
    end

    // Bypass lets WB results reach the instruction decoded in the same cycle
    assign ReadData1 = (w_rs == 5'd0)                          ? 32'd0     :
                       (w_wr_en && (WriteRegister == w_rs))    ? WriteData :
                                                                 r_gpr[w_rs];
    assign ReadData2 = (w_rt == 5'd0)                          ? 32'd0     :
                       (w_wr_en && (WriteRegister == w_rt))    ? WriteData :
                                                                 r_gpr[w_rt];

    assign w_zext = (w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI);
    assign w_jal  = (w_op == OP_JAL);

    assign SignExtension    = w_zext ? {16'd0, w_imm} : {{16{w_imm[15]}}, w_imm};
    assign PCAddResult_out  = PCAddResult;
    assign instruction_indx = {PCAddResult[31:28], Instruction[25:0], 2'b00};
    assign Rt               = w_rt;
    assign Rd               = w_jal ? 5'd31 : Instruction[15:11];

    always_comb begin
        ALUSrc        = 1'b0;
        ALUOp         = ALU_ADD;
        Branch        = 1'b0;
        BranchLogicOp = BR_BEQ;
        RegDst        = 1'b0;
        RegWrite1     = 1'b0;
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        MemToReg      = 1'b0;
        BitSel        = 2'b00;
        sel_D         = 2'b00;
        if (Instruction != 32'd0) begin
            case (w_op)
                OP_RTYPE: begin
                    RegDst    = 1'b1;
                    RegWrite1 = 1'b1;
                    case (w_funct)
                        6'h20:   ALUOp = ALU_ADD;
                        6'h22:   ALUOp = ALU_SUB;
                        6'h24:   ALUOp = ALU_AND;
                        6'h25:   ALUOp = ALU_OR;
                        6'h26:   ALUOp = ALU_XOR;
                        6'h27:   ALUOp = ALU_NOR;
                        6'h2A:   ALUOp = ALU_SLT;
                        6'h00:   ALUOp = ALU_SLL;
                        6'h02:   ALUOp = ALU_SRL;
                        6'h08: begin
                            RegDst    = 1'b0;
                            RegWrite1 = 1'b0;
                            sel_D     = 2'b10;
                        end
                        default: begin
                            RegDst    = 1'b0;
                            RegWrite1 = 1'b0;
                        end
                    endcase
                end
                OP_MUL: begin
                    if (w_funct == 6'h02) begin
                        RegDst    = 1'b1;
                        RegWrite1 = 1'b1;
                        ALUOp     = ALU_MUL;
                    end
                end
                OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                    ALUSrc    = 1'b1;
                    RegWrite1 = 1'b1;
                    case (w_op)
                        OP_SLTI: ALUOp = ALU_SLT;
                        OP_ANDI: ALUOp = ALU_AND;
                        OP_ORI:  ALUOp = ALU_OR;
                        OP_XORI: ALUOp = ALU_XOR;
                        default: ALUOp = ALU_ADD;
                    endcase
                end
                OP_LW, OP_LH, OP_LB: begin
                    ALUSrc    = 1'b1;
                    MemRead   = 1'b1;
                    MemToReg  = 1'b1;
                    RegWrite1 = 1'b1;
                    BitSel    = (w_op == OP_LW) ? 2'b00 :
                                (w_op == OP_LH) ? 2'b01 : 2'b10;
                end
                OP_SW, OP_SH, OP_SB: begin
                    ALUSrc   = 1'b1;
                    MemWrite = 1'b1;
                    BitSel   = (w_op == OP_SW) ? 2'b00 :
                               (w_op == OP_SH) ? 2'b01 : 2'b10;
                end
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                    Branch = 1'b1;
                    ALUOp  = ALU_SUB;
                    case (w_op)
                        OP_BNE:  BranchLogicOp = BR_BNE;
                        OP_BLEZ: BranchLogicOp = BR_BLEZ;
                        OP_BGTZ: BranchLogicOp = BR_BGTZ;
                        default: BranchLogicOp = BR_BEQ;
                    endcase
                end
                OP_REGIMM: begin
                    if (w_rt == 5'd1) begin
                        Branch        = 1'b1;
                        ALUOp         = ALU_SUB;
                        BranchLogicOp = BR_BGEZ;
                    end else if (w_rt == 5'd0) begin
                        Branch        = 1'b1;
                        ALUOp         = ALU_SUB;
                        BranchLogicOp = BR_BLTZ;
                    end
                end
                OP_J: begin
                    sel_D = 2'b01;
                end
                OP_JAL: begin
                    sel_D     = 2'b01;
                    RegWrite1 = 1'b1;
                    RegDst    = 1'b1;
                    ALUOp     = ALU_LINK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for instruction_decode_stage: directed vectors with
// hand-computed expectations, checked by an independent monitor.
module tb_instruction_decode_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instruction;
    logic [31:0] PCAddResult;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] SignExtension;
    logic [31:0] PCAddResult_out;
    logic [31:0] instruction_indx;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic        ALUSrc;
    logic [3:0]  ALUOp;
    logic        Branch;
    logic [2:0]  BranchLogicOp;
    logic        RegDst;
    logic        RegWrite1;
    logic        MemWrite;
    logic        MemRead;
    logic        MemToReg;
    logic [1:0]  BitSel;
    logic [1:0]  sel_D;

    instruction_decode_stage dut (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction),
        .PCAddResult(PCAddResult), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .SignExtension(SignExtension), .PCAddResult_out(PCAddResult_out),
        .instruction_indx(instruction_indx), .Rt(Rt), .Rd(Rd),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Branch(Branch),
        .BranchLogicOp(BranchLogicOp), .RegDst(RegDst),
        .RegWrite1(RegWrite1), .MemWrite(MemWrite), .MemRead(MemRead),
        .MemToReg(MemToReg), .BitSel(BitSel), .sel_D(sel_D)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [31:0] pco;
        logic [31:0] indx;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [17:0] ctl;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [17:0] C(
        input logic       as,
        input logic [3:0] op,
        input logic       br,
        input logic [2:0] bl,
        input logic       rdst,
        input logic       rw,
        input logic       mw,
        input logic       mr,
        input logic       m2r,
        input logic [1:0] bs,
        input logic [1:0] sd
    );
        return {as, op, br, bl, rdst, rw, mw, mr, m2r, bs, sd};
    endfunction

    task automatic chk(input string nm, input logic [31:0] instr,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s instr=%08h got=%08h want=%08h",
                     nm, instr, act, exp);
        end
    endtask

    task automatic issue(
        input logic [31:0] instr,
        input logic [31:0] pc,
        input logic        we,
        input logic [4:0]  wreg,
        input logic [31:0] wdata,
        input logic [31:0] rd1,
        input logic [31:0] rd2,
        input logic [31:0] sext,
        input logic [4:0]  rd,
        input logic [17:0] ctl
    );
        exp_t e;
        @(posedge Clk);
        #1;
        Instruction   = instr;
        PCAddResult   = pc;
        RegWrite      = we;
        WriteRegister = wreg;
        WriteData     = wdata;
        e.instr = instr;
        e.rd1   = rd1;
        e.rd2   = rd2;
        e.sext  = sext;
        e.pco   = pc;
        e.indx  = {pc[31:28], instr[25:0], 2'b00};
        e.rt    = instr[20:16];
        e.rd    = rd;
        e.ctl   = ctl;
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so they are valid mid-cycle
    initial begin
        exp_t e;
        logic [17:0] act_ctl;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act_ctl = {ALUSrc, ALUOp, Branch, BranchLogicOp, RegDst,
                           RegWrite1, MemWrite, MemRead, MemToReg,
                           BitSel, sel_D};
                chk("ReadData1", e.instr, ReadData1, e.rd1);
                chk("ReadData2", e.instr, ReadData2, e.rd2);
                chk("SignExt", e.instr, SignExtension, e.sext);
                chk("PCout", e.instr, PCAddResult_out, e.pco);
                chk("indx", e.instr, instruction_indx, e.indx);
                chk("Rt", e.instr, {27'd0, Rt}, {27'd0, e.rt});
                chk("Rd", e.instr, {27'd0, Rd}, {27'd0, e.rd});
                chk("ctl", e.instr, {14'd0, act_ctl}, {14'd0, e.ctl});
            end
        end
    end

    localparam logic [17:0] CT_R    = 18'b0_0000_0_000_1_1_0_0_0_00_00;
    localparam logic [17:0] CT_ZERO = 18'd0;

    initial begin
        Reset         = 1'b1;
        Instruction   = 32'd0;
        PCAddResult   = 32'd0;
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 32'd0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // add $10,$8,$9 after reset, then load $8=5, $9=3 via WB
        issue(32'h01095020, 0, 0, 0, 0, 0, 0, 32'h5020, 10, CT_R);
        issue(32'h01095020, 0, 1, 8, 5, 5, 0, 32'h5020, 10, CT_R);
        issue(32'h01095020, 0, 1, 9, 3, 5, 3, 32'h5020, 10, CT_R);
        issue(32'h01095020, 0, 0, 0, 0, 5, 3, 32'h5020, 10, CT_R);
        // mul, sll
        issue(32'h71095002, 0, 0, 0, 0, 5, 3, 32'h5002, 10,
              C(0, 4'b1001, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        issue(32'h00094080, 0, 0, 0, 0, 0, 3, 32'h4080, 8,
              C(0, 4'b0110, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        // immediates
        issue(32'h20080005, 0, 0, 0, 0, 0, 5, 32'h5, 0,
              C(1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        issue(32'h2008FFFF, 0, 0, 0, 0, 0, 5, 32'hFFFFFFFF, 31,
              C(1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        issue(32'h3008FFFF, 0, 0, 0, 0, 0, 5, 32'h0000FFFF, 31,
              C(1, 4'b0010, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // memory
        issue(32'hADA80000, 0, 0, 0, 0, 0, 5, 32'h0, 0,
              C(1, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
        issue(32'h85B20006, 0, 0, 0, 0, 0, 0, 32'h6, 0,
              C(1, 4'b0000, 0, 0, 0, 1, 0, 1, 1, 2'b01, 0));
        issue(32'hA1A90004, 0, 0, 0, 0, 0, 3, 32'h4, 0,
              C(1, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 2'b10, 0));
        // branches
        issue(32'h1108000B, 0, 0, 0, 0, 5, 5, 32'hB, 0,
              C(0, 4'b0001, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        issue(32'h1509000B, 0, 0, 0, 0, 5, 3, 32'hB, 0,
              C(0, 4'b0001, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0));
        issue(32'h0501000B, 0, 0, 0, 0, 5, 0, 32'hB, 0,
              C(0, 4'b0001, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0));
        issue(32'h1D00000B, 0, 0, 0, 0, 5, 0, 32'hB, 0,
              C(0, 4'b0001, 1, 3'b011, 0, 0, 0, 0, 0, 0, 0));
        issue(32'h1900000B, 0, 0, 0, 0, 5, 0, 32'hB, 0,
              C(0, 4'b0001, 1, 3'b100, 0, 0, 0, 0, 0, 0, 0));
        issue(32'h0520000B, 0, 0, 0, 0, 3, 0, 32'hB, 0,
              C(0, 4'b0001, 1, 3'b101, 0, 0, 0, 0, 0, 0, 0));
        // jumps
        issue(32'h0C0000EA, 32'h1, 0, 0, 0, 0, 0, 32'hEA, 31,
              C(0, 4'b1111, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01));
        issue(32'h08000010, 32'hA0000004, 0, 0, 0, 0, 0, 32'h10, 0,
              C(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        issue(32'h03E00008, 0, 0, 0, 0, 0, 0, 32'h8, 0,
              C(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10));
        // NOP and unknown opcode
        issue(32'h00000000, 0, 0, 0, 0, 0, 0, 32'h0, 0, CT_ZERO);
        issue(32'hFC000000, 32'h30000000, 0, 0, 0, 0, 0, 32'h0, 0, CT_ZERO);
        // $0 is never written
        issue(32'h00000000, 0, 1, 0, 2, 0, 0, 32'h0, 0, CT_ZERO);
        issue(32'h00000000, 0, 0, 0, 0, 0, 0, 32'h0, 0, CT_ZERO);
        // same-cycle bypass on rs=$9, then array read afterwards
        issue(32'h01204020, 0, 1, 9, 32'h1234, 32'h1234, 0, 32'h4020, 8, CT_R);
        issue(32'h01204020, 0, 0, 0, 0, 32'h1234, 0, 32'h4020, 8, CT_R);

        @(posedge Clk);
        #1;
        RegWrite = 1'b0;
        repeat (3) @(posedge Clk);
        chk("queue_drained", 32'd0, q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
